// File: rtl/key_scheduler_if.sv
// Handshake bundle between the top-level search FSM, the crack cores and
// the key scheduler. The scheduler sits on the slave side.
interface key_scheduler_if #(
  parameter int N_CORES = 4
);
  logic                    start;
  logic                    abort;
  logic [N_CORES-1:0]      req;
  logic [N_CORES-1:0]      grant;
  logic [23:0]             chunk_base;
  logic [N_CORES-1:0]      core_done;
  logic [N_CORES-1:0]      core_found;
  logic [24*N_CORES-1:0]   found_key_flat;
  logic                    busy;
  logic                    done;
  logic                    key_valid;
  logic [23:0]             key;
  logic                    stop;

  modport master (
    output start, abort, req, core_done, core_found, found_key_flat,
    input  grant, chunk_base, busy, done, key_valid, key, stop
  );

  modport slave (
    input  start, abort, req, core_done, core_found, found_key_flat,
    output grant, chunk_base, busy, done, key_valid, key, stop
  );
endinterface

// File: rtl/key_scheduler.sv
// Round-robin work distributor for the ARC4 key search. Hands out
// 2^CHUNK_BITS-key chunks of the 24-bit key space, counts chunks still in
// flight, latches the first recovered key and raises a global stop.
module key_scheduler #(
  parameter int N_CORES    = 4,
  parameter int CHUNK_BITS = 16
) (
  input  logic             fst_clk,
  input  logic             rst_n,
  key_scheduler_if.slave   bus
);
  localparam int PW = $clog2(N_CORES);
  localparam int OW = $clog2(N_CORES + 1);
  localparam logic [24:0] STEP = 25'(1) << CHUNK_BITS;
  localparam logic [N_CORES-1:0] ONE = N_CORES'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state;
  logic [24:0]        next_base;   // bit 24 set once the last chunk is out
  logic [OW-1:0]      outstanding;
  logic [PW-1:0]      rr_ptr;
  logic [N_CORES-1:0] grant_q;
  logic [23:0]        chunk_base_q;
  logic               busy_q, done_q, key_valid_q, stop_q;
  logic [23:0]        key_q;

  logic [N_CORES-1:0] elig;
  logic               gnt_hit;
  logic [PW-1:0]      gnt_idx;
  logic [PW-1:0]      rr_next;
  logic [PW:0]        sum;
  logic [PW:0]        inc;
  logic               any_found;
  logic [23:0]        f_key;
  logic [N_CORES-1:0] retire;
  logic [OW-1:0]      ret_cnt;
  logic [OW-1:0]      out_ret;
  logic               exhausted;

  assign exhausted = next_base[24];

  // Round-robin pick; a core's own grant cycle masks its still-high req.
  always_comb begin
    elig    = bus.req & ~grant_q;
    gnt_hit = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int off = 0; off < N_CORES; off++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N_CORES)) sum = sum - (PW+1)'(N_CORES);
      if (!gnt_hit && elig[sum[PW-1:0]]) begin
        gnt_hit = 1'b1;
        gnt_idx = sum[PW-1:0];
      end
    end
    inc     = {1'b0, gnt_idx} + (PW+1)'(1);
    rr_next = (inc == (PW+1)'(N_CORES)) ? '0 : inc[PW-1:0];
  end

  // Lowest-index finder wins when several report a key in the same cycle.
  always_comb begin
    any_found = |bus.core_found;
    f_key     = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (bus.core_found[i]) f_key = bus.found_key_flat[24*i +: 24];
    end
  end

  // Chunks retired this edge, netted against the in-flight count.
  always_comb begin
    retire  = bus.core_done | bus.core_found;
    ret_cnt = '0;
    for (int i = 0; i < N_CORES; i++) ret_cnt = ret_cnt + OW'(retire[i]);
    out_ret = outstanding - ret_cnt;
  end

  // Search control: IDLE -> RUN -> DONE, DONE held until start.
  always_ff @(posedge fst_clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      next_base    <= '0;
      outstanding  <= '0;
      rr_ptr       <= '0;
      grant_q      <= '0;
      chunk_base_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      key_valid_q  <= 1'b0;
      key_q        <= '0;
      stop_q       <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          grant_q <= '0;
          if (any_found) begin
            key_q       <= f_key;
            key_valid_q <= 1'b1;
            stop_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state       <= ST_DONE;
          end else if (bus.abort || (exhausted && out_ret == '0)) begin
            key_valid_q <= 1'b0;
            stop_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state       <= ST_DONE;
          end else if (!exhausted && gnt_hit) begin
            grant_q      <= ONE << gnt_idx;
            chunk_base_q <= next_base[23:0];
            next_base    <= next_base + STEP;
            rr_ptr       <= rr_next;
            outstanding  <= out_ret + OW'(1);
          end else begin
            outstanding  <= out_ret;
          end
        end
        default: begin
          // IDLE and DONE: only start matters, core pulses are dropped.
          if (bus.start) begin
            state       <= ST_RUN;
            next_base   <= '0;
            outstanding <= '0;
            rr_ptr      <= '0;
            grant_q     <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.chunk_base = chunk_base_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.key        = key_q;
  assign bus.stop       = stop_q;
endmodule

// File: doc/key_scheduler.md
# key_scheduler

Work-distribution controller for the ARC4 key-search engine. It splits the 24-bit key space into fixed-size chunks and hands them to N_CORES cracking cores with a round-robin request/grant handshake. It tracks outstanding chunks, captures the first recovered key, and broadcasts a stop to all cores. It sits between the competition top-level FSM and the crack cores, replacing static key-space partitioning.

## Interface
- N_CORES, 4, number of crack cores served (2..128)
- CHUNK_BITS, 16, log2 of keys per chunk; chunk count = 2^(24-CHUNK_BITS)
- fst_clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a new search from key 0 (honoured in IDLE and DONE only)
- abort  in  1  one-cycle pulse; ends the search without a key (honoured in RUN only)
- req  in  N_CORES  per-core level request for a chunk
- grant  out  N_CORES  one-hot, one-cycle grant pulse; all-zero when no grant
- chunk_base  out  24  first key of granted chunk, valid while grant is non-zero
- core_done  in  N_CORES  per-core one-cycle pulse: chunk finished, no key found
- core_found  in  N_CORES  per-core one-cycle pulse: key found (also retires the chunk)
- found_key_flat  in  24*N_CORES  core i's key at [24*i+23:24*i], valid with core_found[i]
- busy  out  1  high in RUN
- done  out  1  high in DONE
- key_valid  out  1  search ended with a key
- key  out  24  recovered key
- stop  out  1  level; all cores abandon current work

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE, or DONE with start: clear next_base, outstanding, rr_ptr, key and key_valid; drop stop; go to RUN.
- RUN, evaluated each edge, in priority order:
  1. Any core_found: take the lowest-index asserting core. Latch its key, set key_valid=1, stop=1, go to DONE. No grant is issued at this edge.
  2. abort: set key_valid=0, stop=1, go to DONE. No grant is issued.
  3. Exhausted and outstanding==0 after this edge's retirements: key_valid=0, stop=1, go to DONE.
  4. Otherwise, if not exhausted, issue a grant. Eligible cores are those with req[i]=1 and grant[i]=0 in the current cycle; this masks the core's still-high req during its grant cycle. Search starts at rr_ptr and wraps upward; the first eligible core wins. Register grant=onehot(i) and chunk_base=next_base. Then next_base += 2^CHUNK_BITS and rr_ptr = (i+1) mod N_CORES.
- Exhausted: set when the chunk with base 2^24 - 2^CHUNK_BITS is granted. Tracked with a 25-bit next_base; exhausted = bit 24.
- outstanding: width clog2(N_CORES+1).
  - +1 per grant issued.
  - −popcount(core_done | core_found) at each edge.
  - Grant and retirements at the same edge are netted.
  - Never underflows: pulses from cores without an outstanding chunk are a protocol violation (assertion in bench).
- core_done and core_found are ignored in IDLE and DONE. Late pulses after stop are discarded.
- DONE holds done, key, key_valid and stop until start or reset.
- Core protocol: a core raises req when idle and must drop it in the cycle after its grant. It latches chunk_base in the grant cycle. It pulses exactly one of core_done or core_found per chunk.

## Timing
- Reset values: grant=0, chunk_base=0, busy=0, done=0, key_valid=0, key=0, stop=0.
- All outputs are registered.
- Grant latency: req sampled high at edge k → grant high in the cycle after edge k (1 cycle). At most one grant per cycle.
- With all cores requesting continuously, grants go out on consecutive cycles in round-robin order.
- Found → key/key_valid/stop/done visible 1 cycle after the core_found cycle.
- start → busy=1 the next cycle; the first grant follows one cycle later at the earliest.
- rst_n low at any edge, including mid-RUN: the next cycle shows all reset values, independent of other inputs.

## Test plan
- N_CORES=4, CHUNK_BITS=20, all req held high after start → grants 0001,0010,0100,1000 on consecutive cycles with chunk_base 0x000000, 0x100000, 0x200000, 0x300000.
- Same configuration, model cores pulse core_done 5 cycles after each grant → exactly 16 grants, last chunk_base 0xF00000. done=1 and key_valid=0 one cycle after the final core_done; outstanding never exceeds 4.
- Core 2 pulses core_found with key 0x3A5F01 while others are running → next cycle key=0x3A5F01, key_valid=1, stop=1, done=1, grant=0 thereafter. Later core_done pulses leave outputs unchanged.
- core_found on cores 1 (0x00ABCD) and 3 (0x123456) in the same cycle → key=0x00ABCD.
- abort after 6 grants → DONE with key_valid=0, stop=1. Then start → busy=1, first chunk_base=0x000000, stop=0.
- rst_n low for one cycle mid-RUN with grants in flight → next cycle all outputs at reset values and state IDLE. A subsequent start restarts from key 0.
